// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C register-bus slice.
// Holds the register-bus transaction struct, the data width and the
// LED register map (addresses and MODE bit positions).
package i2c_pkg;

    localparam int unsigned I2C_DATA_WIDTH = 8;
    localparam int unsigned I2C_ADDR_WIDTH = 8;

    typedef struct packed {
        logic [I2C_ADDR_WIDTH-1:0] addr;
        logic [I2C_DATA_WIDTH-1:0] data;
        logic                      write_en;
        logic                      read_en;
    } reg_bus_t;

    localparam logic [I2C_ADDR_WIDTH-1:0] MODE_ADDR      = 8'h00;
    localparam logic [I2C_ADDR_WIDTH-1:0] LEDMASK_ADDR   = 8'h01;
    localparam logic [I2C_ADDR_WIDTH-1:0] DUTY_BASE_ADDR = 8'h02;

    localparam int unsigned MODE_EN_BIT  = 0;
    localparam int unsigned MODE_INV_BIT = 1;

endpackage

// File: rtl/led_regs_if.sv
// led_regs_if: register access bus between the I2C controller (master)
// and led_regs (slave).
//   reg_bus  - addr/data/write_en/read_en request from the controller
//   rd_data  - read-back data
//   rd_valid - one-cycle pulse qualifying rd_data
interface led_regs_if;
    import i2c_pkg::*;

    reg_bus_t                  reg_bus;
    logic [I2C_DATA_WIDTH-1:0] rd_data;
    logic                      rd_valid;

    modport master (output reg_bus, input rd_data, input rd_valid);
    modport slave  (input reg_bus, output rd_data, output rd_valid);

endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one PWM output channel.
// Holds the active duty (reloaded from the shadow duty only at a period wrap
// or while disabled) and the registered LED drive.
//   clk, rst_n      - clock, synchronous active-low reset
//   cnt_i           - shared PWM counter
//   wrap_i          - counter is at max and enabled this cycle
//   en_i, inv_i     - global enable and output invert
//   mask_i          - per-channel enable
//   shadow_duty_i   - software-written duty
//   led_o           - registered drive
module led_pwm_channel #(
    parameter int unsigned PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] cnt_i,
    input  logic                 wrap_i,
    input  logic                 en_i,
    input  logic                 mask_i,
    input  logic                 inv_i,
    input  logic [PWM_WIDTH-1:0] shadow_duty_i,
    output logic                 led_o
);

    logic [PWM_WIDTH-1:0] act_duty_q, act_duty_d;
    logic                 led_q, led_d;

    always_comb begin
        // Reload only between periods so a duty change never cuts a period short.
        act_duty_d = (wrap_i || !en_i) ? shadow_duty_i : act_duty_q;
        led_d      = (en_i & mask_i & (cnt_i < act_duty_q)) ^ inv_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_duty_q <= '0;
            led_q      <= 1'b0;
        end else begin
            act_duty_q <= act_duty_d;
            led_q      <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_regs.sv
// led_regs: register-mapped PWM LED controller.
// Registers: MODE (EN, INV), LEDMASK (channels 0..7), DUTYi shadow duties.
// A free-running PWM counter (held at 0 while disabled) drives NUM_LEDS
// led_pwm_channel instances.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - register bus (reg_bus in, rd_data/rd_valid out)
//   led_out    - registered PWM drive, one bit per channel
module led_regs
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 8,
    parameter int unsigned PWM_WIDTH = I2C_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    led_regs_if.slave           bus,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [1:0]                mode_q, mode_d;
    logic [7:0]                mask_q, mask_d;
    logic [PWM_WIDTH-1:0]      duty_q [NUM_LEDS];
    logic [PWM_WIDTH-1:0]      duty_d [NUM_LEDS];
    logic [PWM_WIDTH-1:0]      cnt_q, cnt_d;
    logic [I2C_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [I2C_DATA_WIDTH-1:0] rd_mux;
    logic                      en, inv, wrap;
    logic [NUM_LEDS-1:0]       mask_vec;

    assign en   = mode_q[MODE_EN_BIT];
    assign inv  = mode_q[MODE_INV_BIT];
    assign wrap = en && (cnt_q == '1);

    always_comb begin
        rd_mux = '0;
        mode_d = mode_q;
        mask_d = mask_q;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            duty_d[i] = duty_q[i];
        end

        // Read mux sees pre-write values, so a same-cycle write+read returns old data.
        if (bus.reg_bus.addr == MODE_ADDR) begin
            rd_mux = {{(I2C_DATA_WIDTH-2){1'b0}}, mode_q};
        end else if (bus.reg_bus.addr == LEDMASK_ADDR) begin
            rd_mux = mask_q;
        end
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (bus.reg_bus.addr == 8'(DUTY_BASE_ADDR + i)) begin
                rd_mux = I2C_DATA_WIDTH'(duty_q[i]);
            end
        end

        if (bus.reg_bus.write_en) begin
            if (bus.reg_bus.addr == MODE_ADDR) begin
                mode_d = bus.reg_bus.data[1:0];
            end else if (bus.reg_bus.addr == LEDMASK_ADDR) begin
                mask_d = bus.reg_bus.data;
            end
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (bus.reg_bus.addr == 8'(DUTY_BASE_ADDR + i)) begin
                    duty_d[i] = PWM_WIDTH'(bus.reg_bus.data);
                end
            end
        end

        cnt_d      = en ? cnt_q + 1'b1 : '0;
        rd_valid_d = bus.reg_bus.read_en;
        rd_data_d  = bus.reg_bus.read_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        // LEDMASK only covers channels 0..7; higher channels are always enabled.
        if (g < 8) begin : g_masked
            assign mask_vec[g] = mask_q[g];
        end else begin : g_unmasked
            assign mask_vec[g] = 1'b1;
        end

        led_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .cnt_i         (cnt_q),
            .wrap_i        (wrap),
            .en_i          (en),
            .mask_i        (mask_vec[g]),
            .inv_i         (inv),
            .shadow_duty_i (duty_q[g]),
            .led_o         (led_out[g])
        );
    end

endmodule

// File: tb/tb_led_regs.sv
module tb_led_regs;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] led_out;

    led_regs_if bus_if ();

    led_regs #(
        .NUM_LEDS  (N),
        .PWM_WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if.slave),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;
    bit chk_on  = 1'b0;

    // Behavioural model: integer register file and period counter.
    int       m_mode, m_mask, m_cnt;
    int       m_shadow [N];
    int       m_active [N];
    logic [7:0] exp_led;
    logic [7:0] exp_rd;
    logic       exp_valid;
    int         exp_phase;   // counter value that produced the current led_out

    task automatic check(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_read(input int a);
        if (a == 0) return m_mode;
        if (a == 1) return m_mask;
        if (a >= 2 && a < 2 + N) return m_shadow[a-2];
        return 0;
    endfunction

    always @(posedge clk) begin
        int a, d;
        bit en, inv;
        a = int'(bus_if.reg_bus.addr);
        d = int'(bus_if.reg_bus.data);
        if (!rst_n) begin
            m_mode = 0; m_mask = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
            exp_led = '0; exp_rd = '0; exp_valid = 1'b0; exp_phase = 0;
        end else begin
            en  = (m_mode & 1) != 0;
            inv = (m_mode & 2) != 0;
            for (int i = 0; i < N; i++)
                exp_led[i] = (en && ((m_mask >> i) & 1) == 1 && m_cnt < m_active[i]) ^ inv;
            exp_phase = m_cnt;
            exp_valid = bus_if.reg_bus.read_en;
            if (bus_if.reg_bus.read_en) exp_rd = 8'(model_read(a));
            if (!en || m_cnt == 255)
                for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
            m_cnt = en ? (m_cnt + 1) % 256 : 0;
            if (bus_if.reg_bus.write_en) begin
                if (a == 0) m_mode = d & 3;
                else if (a == 1) m_mask = d;
                else if (a >= 2 && a < 2 + N) m_shadow[a-2] = d;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("led_out", int'(led_out), int'(exp_led));
            check("rd_valid", int'(bus_if.rd_valid), int'(exp_valid));
            check("rd_data", int'(bus_if.rd_data), int'(exp_rd));
        end
    end

    task automatic bus_idle();
        bus_if.reg_bus = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.reg_bus.addr = a; bus_if.reg_bus.data = d;
        bus_if.reg_bus.write_en = 1'b1; bus_if.reg_bus.read_en = 1'b0;
        @(negedge clk);
        bus_idle();
    endtask

    // Read (optionally with a concurrent write) and check the literal result.
    task automatic rd(input string name, input logic [7:0] a, input bit we,
                      input logic [7:0] d, input int exp);
        @(negedge clk);
        bus_if.reg_bus.addr = a; bus_if.reg_bus.data = d;
        bus_if.reg_bus.write_en = we; bus_if.reg_bus.read_en = 1'b1;
        @(negedge clk);
        bus_idle();
        check({name, " valid"}, int'(bus_if.rd_valid), 1);
        check(name, int'(bus_if.rd_data), exp);
    endtask

    task automatic wait_phase0();
        int b = 0;
        do begin @(negedge clk); b++; end while (exp_phase != 0 && b < 1000);
        if (exp_phase != 0) begin
            asserts++; fails++;
            $display("FAIL wait_phase0: got phase %0d, expected 0 within 1000 cycles", exp_phase);
        end
    endtask

    task automatic count_period(input int b, output int hi);
        wait_phase0();
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out[b]) hi++;
            @(negedge clk);
        end
    endtask

    initial begin
        int hi;
        rst_n = 1'b0;
        bus_idle();
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state and reads of the first three registers.
        check("reset led_out", int'(led_out), 0);
        rd("rd MODE", 8'h00, 1'b0, 8'h00, 0);
        rd("rd LEDMASK", 8'h01, 1'b0, 8'h00, 0);
        rd("rd DUTY0", 8'h02, 1'b0, 8'h00, 0);

        // 25% duty on channel 0.
        wr(8'h02, 8'h40);
        wr(8'h01, 8'h01);
        wr(8'h00, 8'h01);
        count_period(0, hi);
        check("duty40 high cycles", hi, 64);
        check("led_out[7:1] off", int'(led_out[7:1]), 0);

        // Mid-period duty change only takes effect at the next period.
        wait_phase0();
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out[0]) hi++;
            if (exp_phase == 8'h0F) begin
                bus_if.reg_bus.addr = 8'h02; bus_if.reg_bus.data = 8'h80;
                bus_if.reg_bus.write_en = 1'b1;
            end else if (exp_phase == 8'h10) begin
                bus_idle();
            end
            @(negedge clk);
        end
        check("old period keeps 0x40", hi, 64);
        count_period(0, hi);
        check("new period 0x80", hi, 128);

        // Maximum duty: on 255 of 256.
        wr(8'h02, 8'hFF);
        count_period(0, hi);
        count_period(0, hi);
        check("duty FF high cycles", hi, 255);

        // Inverted with zero duty: constantly on.
        wr(8'h02, 8'h00);
        wr(8'h00, 8'h03);
        count_period(0, hi);
        count_period(0, hi);
        check("inv duty0 high cycles", hi, 256);
        check("inv all on", int'(led_out), 8'hFF);

        // Disabled: output is INV on every channel.
        wr(8'h00, 8'h02);
        repeat (2) @(negedge clk);
        check("EN=0 INV=1", int'(led_out), 8'hFF);
        wr(8'h00, 8'h00);
        repeat (2) @(negedge clk);
        check("EN=0 INV=0", int'(led_out), 8'h00);

        // Unmapped address.
        wr(8'h30, 8'h5A);
        rd("rd unmapped", 8'h30, 1'b0, 8'h00, 0);
        rd("rd MODE after unmapped", 8'h00, 1'b0, 8'h00, 0);
        rd("rd LEDMASK after unmapped", 8'h01, 1'b0, 8'h00, 1);

        // Simultaneous write and read returns the old value.
        wr(8'h03, 8'h11);
        rd("rw DUTY1 old", 8'h03, 1'b1, 8'hAA, 8'h11);
        rd("rd DUTY1 new", 8'h03, 1'b0, 8'h00, 8'hAA);

        // Reset in the middle of a running period and a read.
        wr(8'h00, 8'h01);
        repeat (50) @(negedge clk);
        bus_if.reg_bus.addr = 8'h00; bus_if.reg_bus.read_en = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        check("led_out after reset", int'(led_out), 0);
        rd("rd MODE after reset", 8'h00, 1'b0, 8'h00, 0);
        rd("rd DUTY1 after reset", 8'h03, 1'b0, 8'h00, 0);
        repeat (3) @(negedge clk);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/led_regs.md
LED_REGS -- requirements
Module: led_regs

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, giving the number of LED channels (range 1..13).
REQ-002 The block SHALL have parameter PWM_WIDTH, default I2C_DATA_WIDTH (8), giving the duty and counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port reg_bus, input, reg_bus_t: the register access bus from the I2C controller, carrying addr, data, write_en and read_en.
REQ-006 The block SHALL have port rd_data, output, I2C_DATA_WIDTH bits: read-back data.
REQ-007 The block SHALL have port rd_valid, output, 1 bit: a one-cycle pulse qualifying rd_data.
REQ-008 The block SHALL have port led_out, output, NUM_LEDS bits: the registered PWM drive, one bit per channel.

Function
REQ-009 Register map:
- 0x00 MODE: bit0 = EN (global enable), bit1 = INV (output invert), bits7:2 read as 0.
- 0x01 LEDMASK: per-channel enable for channels 0..7, bit i = channel i.
- 0x02+i DUTYi: shadow duty for channel i, i < NUM_LEDS.
REQ-010 A write to any unmapped address SHALL be ignored; a read of any unmapped address SHALL return 0x00.
REQ-011 When write_en is high in cycle N, the addressed register SHALL hold reg_bus.data from cycle N+1.
REQ-012 When read_en is high in cycle N, rd_data SHALL present the register value with rd_valid high in cycle N+1 only; rd_data SHALL hold its last value while rd_valid is low.
REQ-013 When write_en and read_en are both high in the same cycle, the write SHALL be performed and rd_data SHALL return the pre-write value.
REQ-014 A read of DUTYi SHALL return the shadow value, not the active value.
REQ-015 The PWM counter SHALL be PWM_WIDTH bits and SHALL increment by 1 each cycle while EN=1, wrapping from 2^PWM_WIDTH-1 to 0.
REQ-016 While EN=0, the PWM counter SHALL be held at 0.
REQ-017 Each channel's active duty SHALL load from its shadow duty only in the cycle where the counter wraps (counter = max and EN=1), or in any cycle while EN=0, so duty changes never glitch mid-period.
REQ-018 The raw output SHALL be EN & LEDMASK[i] & (counter < active_duty[i]), registered; led_out[i] SHALL equal raw XOR INV.
REQ-019 Boundaries:
- duty = 0 SHALL give an always-off raw output.
- duty = 2^PWM_WIDTH-1 SHALL give a raw output on for 255 of every 256 cycles.
- With EN=0, led_out SHALL equal {NUM_LEDS{INV}}.
REQ-020 When the counter wraps in the same cycle that DUTYi is written, the active duty SHALL load the old shadow value; the new value takes effect at the next wrap.

Reset
REQ-021 When rst_n=0 at a rising clk edge, the block SHALL clear the following at that edge:
- MODE, LEDMASK and all shadow and active duties to 0.
- The counter to 0.
- rd_data to 0x00 and rd_valid to 0.
- led_out to all zeros.
REQ-022 A reset asserted mid-period or mid-read SHALL abort all activity; the first access after reset release SHALL be serviced normally.

Structure
REQ-023 Register address constants (MODE_ADDR, LEDMASK_ADDR, DUTY_BASE_ADDR) and the MODE bit positions (MODE_EN_BIT, MODE_INV_BIT) SHALL be added to i2c_pkg.
REQ-024 Each channel SHALL be a sub-module, led_pwm_channel, instantiated NUM_LEDS times.
- Inputs: shared counter, wrap strobe, EN, mask bit, INV, shadow duty.
- Contents: the active-duty register and the led_out flop.

Verification
REQ-025 Reset then read 0x00, 0x01, 0x02 -> each returns 0x00 with rd_valid one cycle after read_en; led_out = 0x00.
REQ-026 Write DUTY0 = 0x40, LEDMASK = 0x01, MODE = 0x01 -> after the first wrap, led_out[0] is high for exactly 64 of every 256 cycles and led_out[7:1] = 0.
REQ-027 Write DUTY0 = 0x80 at counter 0x10 of a running period -> the current period still shows 0x40 high cycles; the next period shows 0x80.
REQ-028 Write MODE = 0x03 with DUTY0 = 0 -> led_out[0] is constantly 1 (inverted off) and unmasked channels read 1.
REQ-029 Write 0x5A to address 0x30, then read 0x30 -> read returns 0x00 and no register changes.
REQ-030 Simultaneous write DUTY1 = 0xAA and read of DUTY1 (old value 0x11) -> rd_data = 0x11; a subsequent read returns 0xAA.
